// File: rtl/audio_pkg.sv
// audio_pkg: shared defaults, fetch FSM state type and sample byte-swap helper.
package audio_pkg;
  localparam int NUM_CHANNELS_DEF = 8;
  localparam int SAMPLE_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, SCAN, ADDR, DATA} fetch_state_t;
  function automatic logic [15:0] byte_swap16(input logic [15:0] d);
    return {d[7:0], d[15:8]};
  endfunction
endpackage

// File: rtl/sample_fetch_scheduler_next_channel_finder.sv
// next_channel_finder: lowest set mask bit at or above start_i; start_i may equal N (nothing found).
module next_channel_finder #(
  parameter int N = 8,
  parameter int CW = $clog2(N)
) (
  input  logic [N-1:0]  mask_i,
  input  logic [CW:0]   start_i,
  output logic          found_o,
  output logic [CW-1:0] idx_o
);
  always_comb begin
    found_o = 1'b0;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--)
      if (mask_i[i] && i >= int'(start_i)) begin
        found_o = 1'b1;
        idx_o = CW'(i);
      end
  end
endmodule

// File: rtl/sample_fetch_scheduler.sv
// sample_fetch_scheduler: per-tick round of single-outstanding AXI-Lite sample reads over playing channels.
// Optional SAMPLE_FETCH_RRESP_ZERO_EN: error responses deliver zero samples and set sticky fetch_err.
module sample_fetch_scheduler
  import audio_pkg::*;
#(
  parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
  parameter int ADDR_W = 32,
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 tick,
  input  logic [NUM_CHANNELS-1:0]              playing,
  input  logic [NUM_CHANNELS-1:0][ADDR_W-1:0]  next_addr,
  output logic [ADDR_W-1:0]                    m_axil_araddr,
  output logic                                 m_axil_arvalid,
  input  logic                                 m_axil_arready,
  input  logic [SAMPLE_W-1:0]                  m_axil_rdata,
  input  logic [1:0]                           m_axil_rresp,
  input  logic                                 m_axil_rvalid,
  output logic                                 m_axil_rready,
  output logic [SAMPLE_W-1:0]                  sample_out,
  output logic [NUM_CHANNELS-1:0]              sample_valid,
  output logic                                 busy,
  output logic                                 overrun,
  output logic                                 fetch_err
);
  localparam int CW = $clog2(NUM_CHANNELS);
  fetch_state_t state_q, state_d;
  logic [NUM_CHANNELS-1:0] mask_q, sample_valid_q;
  logic [CW:0] idx_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [SAMPLE_W-1:0] sample_out_q, rdata_sw;
  logic overrun_q, found, rd_err, rd_done;
  logic [CW-1:0] fidx;
  next_channel_finder #(.N(NUM_CHANNELS), .CW(CW)) u_finder (
    .mask_i(mask_q), .start_i(idx_q), .found_o(found), .idx_o(fidx)
  );
  assign rdata_sw = SAMPLE_W'(byte_swap16(16'(m_axil_rdata)));
  assign rd_done = state_q == DATA && m_axil_rvalid;
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  always_comb begin
    state_d = state_q == IDLE ? (tick ? SCAN : IDLE) :
              state_q == SCAN ? (found ? ADDR : IDLE) :
              state_q == ADDR ? (m_axil_arready ? DATA : ADDR) :
                                (m_axil_rvalid ? SCAN : DATA);
  end
  always_comb begin
    m_axil_arvalid = state_q == ADDR;
    m_axil_rready = state_q == DATA;
    busy = state_q != IDLE;
    m_axil_araddr = araddr_q;
    sample_out = sample_out_q;
    sample_valid = sample_valid_q;
    overrun = overrun_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
      idx_q <= '0;
      araddr_q <= '0;
      sample_out_q <= '0;
      sample_valid_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= tick && state_q != IDLE;
      sample_valid_q <= '0;
      if (state_q == IDLE && tick) begin
        mask_q <= playing;
        idx_q <= '0;
      end
      if (state_q == SCAN && found) begin
        idx_q <= {1'b0, fidx};
        araddr_q <= next_addr[fidx];
      end
      if (rd_done) begin
        sample_out_q <= rd_err ? '0 : rdata_sw;
        sample_valid_q <= NUM_CHANNELS'(1) << idx_q[CW-1:0];
        idx_q <= idx_q + 1'b1;
      end
    end
  end
`ifdef SAMPLE_FETCH_RRESP_ZERO_EN
  logic fetch_err_q;
  assign rd_err = |m_axil_rresp;
  always_ff @(posedge clk) fetch_err_q <= rst ? 1'b0 : (fetch_err_q || (rd_done && rd_err));
  assign fetch_err = fetch_err_q;
`else
  logic unused_rresp;
  assign unused_rresp = ^m_axil_rresp;
  assign rd_err = 1'b0;
  assign fetch_err = 1'b0;
`endif
endmodule

// File: tb/tb_sample_fetch_scheduler.sv
// tb_sample_fetch_scheduler: directed plus random stimulus against a queue-based round model.
module tb_sample_fetch_scheduler;
  localparam int N = 8, AW = 32, SW = 16;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0;
  logic [N-1:0] playing = '0;
  logic [N-1:0][AW-1:0] next_addr;
  logic arready = 1'b1, rvalid = 1'b1;
  logic [SW-1:0] rdata = '0;
  logic [1:0] rresp = 2'b00;
  logic [AW-1:0] araddr;
  logic arvalid, rready, busy, overrun, fetch_err;
  logic [SW-1:0] sample_out;
  logic [N-1:0] sample_valid;
  int total = 0, bad = 0;
  bit e_busy, e_arv, e_rr, e_ovr, e_err;
  logic [N-1:0] e_sv;
  logic [SW-1:0] e_so;
  logic [AW-1:0] e_addr;
  int chq[$];
  always #5 clk = ~clk;
  sample_fetch_scheduler dut (
    .clk(clk), .rst(rst), .tick(tick), .playing(playing), .next_addr(next_addr),
    .m_axil_araddr(araddr), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready),
    .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy), .overrun(overrun),
    .fetch_err(fetch_err)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  // One clock edge of the behavioural model: a round is a queue of channels, each costing a scan cycle, an address phase and a data phase.
  task automatic model_edge();
    bit n_ovr;
    bit er;
    logic [N-1:0] n_sv;
    n_ovr = tick && e_busy;
    n_sv = '0;
    if (rst) begin
      {e_busy, e_arv, e_rr, e_ovr, e_err} = '0;
      e_sv = '0;
      e_so = '0;
      chq.delete();
      return;
    end
    if (!e_busy) begin
      if (tick) begin
        chq.delete();
        for (int i = 0; i < N; i++) if (playing[i]) chq.push_back(i);
        e_busy = 1'b1;
      end
    end else if (e_arv) begin
      if (arready) begin
        e_arv = 1'b0;
        e_rr = 1'b1;
      end
    end else if (e_rr) begin
      if (rvalid) begin
        e_rr = 1'b0;
        n_sv[chq[0]] = 1'b1;
        chq.pop_front();
`ifdef SAMPLE_FETCH_RRESP_ZERO_EN
        er = rresp != 2'b00;
`else
        er = 1'b0;
`endif
        if (er) e_err = 1'b1;
        e_so = er ? '0 : {rdata[7:0], rdata[15:8]};
      end
    end else if (chq.size() > 0) begin
      e_arv = 1'b1;
      e_addr = next_addr[chq[0]];
    end else e_busy = 1'b0;
    e_ovr = n_ovr;
    e_sv = n_sv;
  endtask
  task automatic compare();
    check("busy", busy, e_busy);
    check("arvalid", arvalid, e_arv);
    check("rready", rready, e_rr);
    check("sample_valid", sample_valid, e_sv);
    check("sample_out", sample_out, e_so);
    check("overrun", overrun, e_ovr);
    check("fetch_err", fetch_err, e_err);
    if (e_arv) check("araddr", araddr, e_addr);
  endtask
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask
  initial begin
    logic [N-1:0] exp_order [4];
    int k;
    exp_order = '{8'h01, 8'h04, 8'h20, 8'h80};
    for (int i = 0; i < N; i++) next_addr[i] = 32'h1000_0000 + 32'(i * 2);
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    // Four-channel round with the slave always ready.
    playing = 8'hA5;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    k = 0;
    repeat (16) begin
      cyc();
      if (sample_valid != '0 && k < 4) begin
        check("round_order", sample_valid, exp_order[k]);
        k++;
      end
    end
    check("round_pulses", k, 4);
    // Byte swap on channel 3.
    playing = 8'h08;
    rdata = 16'h3412;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    repeat (6) begin
      cyc();
      if (e_sv == 8'h08) check("swap_ch3", sample_out, 16'h1234);
    end
    // Address channel stalled.
    playing = 8'h02;
    arready = 1'b0;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    repeat (7) cyc();
    arready = 1'b1;
    repeat (5) cyc();
    // Tick during a round.
    playing = 8'h03;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    repeat (10) cyc();
    // Reset while waiting for read data.
    playing = 8'h01;
    rvalid = 1'b0;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    for (int i = 0; i < 10 && !e_rr; i++) cyc();
    check("in_data", rready, 1'b1);
    rst = 1'b1;
    rvalid = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (3) cyc();
`ifdef SAMPLE_FETCH_RRESP_ZERO_EN
    playing = 8'h02;
    rresp = 2'b10;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    rresp = 2'b00;
    repeat (6) cyc();
    check("err_sticky", fetch_err, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
`endif
    // Random traffic with occasional resets.
    repeat (2000) begin
      tick = $urandom_range(0, 7) == 0;
      playing = N'($urandom);
      arready = $urandom_range(0, 9) < 7;
      rvalid = $urandom_range(0, 9) < 7;
      rdata = SW'($urandom);
      rresp = $urandom_range(0, 7) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 3) == 0) next_addr[$urandom_range(0, N - 1)] = $urandom;
      rst = $urandom_range(0, 299) == 0;
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sample_fetch_scheduler.md
SAMPLE_FETCH_SCHEDULER -- requirements
Module: sample_fetch_scheduler

Interface
REQ-001 Parameter NUM_CHANNELS, default 8, number of audio channels served.
REQ-002 Parameter ADDR_W, default 32, AXI-Lite address width.
REQ-003 Parameter SAMPLE_W, default 16, sample and read-data width.
REQ-004 clk  in  1  single clock for all logic, also the AXI-Lite aclk.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 tick  in  1  one-cycle sample-rate strobe that starts a fetch round.
REQ-007 playing  in  NUM_CHANNELS  per-channel enable; a 0 bit means that channel is skipped.
REQ-008 next_addr  in  NUM_CHANNELS x ADDR_W  per-channel next-sample byte address.
REQ-009 m_axil_araddr  out  ADDR_W; m_axil_arvalid out 1; m_axil_arready in 1; all form the AXI-Lite read-address channel.
REQ-010 m_axil_rdata  in  SAMPLE_W; m_axil_rresp in 2; m_axil_rvalid in 1; m_axil_rready out 1; all form the AXI-Lite read-data channel.
REQ-011 sample_out  out  SAMPLE_W  fetched sample, byte-swapped.
REQ-012 sample_valid  out  NUM_CHANNELS  one-hot, one-cycle strobe marking the channel that owns sample_out.
REQ-013 busy  out  1  high while a fetch round is in progress; overrun out 1 is a one-cycle pulse.

Function
REQ-014 The FSM SHALL have four states: IDLE, SCAN, ADDR and DATA.
REQ-015 IDLE: tick=1 latches playing into round_mask, sets idx=0 and moves to SCAN; busy=0 only in IDLE.
REQ-016 SCAN: in one cycle, find the lowest set round_mask bit at or above idx; found -> idx=that bit, go to ADDR; none -> go to IDLE.
REQ-017 ADDR: m_axil_arvalid=1 and m_axil_araddr=next_addr[idx], registered on entry and stable until the handshake; on arvalid&arready go to DATA.
REQ-018 DATA: m_axil_rready=1; on rvalid&rready register sample_out={rdata[7:0],rdata[15:8]}, pulse sample_valid[idx] on the next cycle, set idx=idx+1 and go to SCAN.
REQ-019 At most one outstanding read at a time; arvalid and rready are never high together.
REQ-020 Latency with arready and rvalid held 1: tick at T -> arvalid at T+2 -> rready at T+3 -> sample_valid at T+4; each extra playing channel adds 3 cycles.
REQ-021 A tick outside IDLE is ignored and pulses overrun for one cycle; the round in progress is unaffected.
REQ-022 Changes to playing during a round are ignored; only round_mask is used.
REQ-023 playing == 0 at tick: SCAN -> IDLE, no AXI activity, no sample_valid.
REQ-024 idx reaching NUM_CHANNELS ends the round (wrap to IDLE); the index never exceeds NUM_CHANNELS-1 on any output.
REQ-025 m_axil_awvalid, m_axil_wvalid and m_axil_bready are not driven by this block; the write channel is tied off by the parent.

Reset
REQ-026 While rst=1: state=IDLE, idx=0, round_mask=0, and arvalid, rready, busy, overrun, sample_valid and sample_out all read 0 on the next edge.
REQ-027 rst mid-transaction drops arvalid/rready on the next edge without waiting for AXI completion; the slave is reset on the same rst.

Configuration
REQ-028 Macro SAMPLE_FETCH_RRESP_ZERO_EN defined: rresp != 0 delivers sample_out=0 with the normal sample_valid pulse and sets a sticky output fetch_err (1 bit), cleared only by rst.
REQ-029 SAMPLE_FETCH_RRESP_ZERO_EN undefined: rresp is ignored, rdata is delivered as-is, and fetch_err is tied 0.

Structure
REQ-030 Package audio_pkg holds NUM_CHANNELS_DEF=8, SAMPLE_W_DEF=16, the fetch_state_t enum (IDLE, SCAN, ADDR, DATA) and the byte_swap16 function.
REQ-031 One sub-module, next_channel_finder: combinational priority encoder with inputs (mask, start idx) and outputs (found, idx).

Verification
REQ-032 playing=8'hA5, tick, arready=rvalid=1 -> araddr sequence from channels 0,2,5,7; sample_valid 01,04,20,80; busy falls 1 cycle after the last pulse.
REQ-033 rdata=16'h3412 for channel 3 -> sample_out=16'h1234 with sample_valid=8'h08.
REQ-034 arready held 0 for 5 cycles -> arvalid and araddr stable all 5 cycles; rready stays 0 until the address handshake.
REQ-035 Second tick 2 cycles after the first -> one overrun pulse; the first round completes unchanged.
REQ-036 rst asserted while in DATA -> next cycle state IDLE, rready=0, no sample_valid pulse.
REQ-037 With SAMPLE_FETCH_RRESP_ZERO_EN, rresp=2'b10 on channel 1 -> sample_out=0, sample_valid=8'h02, fetch_err=1 until rst.
